// File: rtl/mem_resp_queue.sv
// In-order memory-response queue between EX and WB: tracks up to DEPTH in-flight
// instructions, aligns load data, drops responses for flushed requests. Optional: MEM_RESP_FWD_EN.
module mem_resp_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_is_mem,
    input  logic                       in_is_load,
    input  logic [6:0]                 in_ld_type,
    input  logic [1:0]                 in_offset,
    input  logic [31:0]                in_rt_value,
    input  logic [31:0]                in_result,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic                       dcache_data_ok,
    input  logic [31:0]                dcache_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [PAYLOAD_W-1:0]       out_payload,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     outstanding
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // one-hot bit positions of {lb,lbu,lh,lhu,lw,lwl,lwr}
    localparam int LD_LB  = 6;
    localparam int LD_LBU = 5;
    localparam int LD_LH  = 4;
    localparam int LD_LHU = 3;
    localparam int LD_LW  = 2;
    localparam int LD_LWL = 1;
    localparam int LD_LWR = 0;

    function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                               input logic [6:0]  ld_type,
                                               input logic [1:0]  off,
                                               input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        r = rdata;
        if (ld_type[LD_LB])       r = {{24{b[7]}}, b};
        else if (ld_type[LD_LBU]) r = {24'h0, b};
        else if (ld_type[LD_LH])  r = {{16{h[15]}}, h};
        else if (ld_type[LD_LHU]) r = {16'h0, h};
        else if (ld_type[LD_LW])  r = rdata;
        else if (ld_type[LD_LWL]) begin
            case (off)
                2'd0:    r = {rdata[7:0],  rt[23:0]};
                2'd1:    r = {rdata[15:0], rt[15:0]};
                2'd2:    r = {rdata[23:0], rt[7:0]};
                default: r = rdata;
            endcase
        end else if (ld_type[LD_LWR]) begin
            case (off)
                2'd0:    r = rdata;
                2'd1:    r = {rt[31:24], rdata[31:8]};
                2'd2:    r = {rt[31:16], rdata[31:16]};
                default: r = {rt[31:8],  rdata[31:24]};
            endcase
        end
        return r;
    endfunction

    logic [PTR_W-1:0] head, tail, pend, mem_wr;
    logic [CNT_W-1:0] count, pend_cnt, drop_cnt;

    logic                 e_done    [DEPTH];
    logic                 e_is_load [DEPTH];
    logic [6:0]           e_ld_type [DEPTH];
    logic [1:0]           e_off     [DEPTH];
    logic [31:0]          e_rt      [DEPTH];
    logic [31:0]          e_result  [DEPTH];
    logic [PAYLOAD_W-1:0] e_payload [DEPTH];
    // queue slots of pending mem entries, oldest at pend
    logic [PTR_W-1:0]     mem_idx   [DEPTH];

    logic             enq, enq_mem, deq, drop, cpl, fwd_hit;
    logic [PTR_W-1:0] cpl_slot;
    logic [31:0]      cpl_data, cpl_result;

    assign in_ready    = (count < CNT_W'(DEPTH)) && !flush && !reset;
    assign enq         = in_valid && in_ready;
    assign enq_mem     = enq && in_is_mem;
    assign drop        = dcache_data_ok && (drop_cnt != '0) && !flush && !reset;
    assign cpl         = dcache_data_ok && (drop_cnt == '0) && (pend_cnt != '0) && !flush && !reset;
    assign cpl_slot    = mem_idx[pend];
    assign cpl_data    = align_load(dcache_rdata, e_ld_type[cpl_slot], e_off[cpl_slot], e_rt[cpl_slot]);
    assign cpl_result  = e_is_load[cpl_slot] ? cpl_data : e_result[cpl_slot];
    assign deq         = out_valid && out_ready;
    assign outstanding = pend_cnt + drop_cnt;
    assign out_payload = e_payload[head];

`ifdef MEM_RESP_FWD_EN
    assign fwd_hit = cpl && (count != '0) && (cpl_slot == head);
`else
    assign fwd_hit = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        out_valid  = 1'b0;
        out_result = '0;
        if (!reset && !flush) begin
            if ((count != '0) && e_done[head]) begin
                out_valid  = 1'b1;
                out_result = e_result[head];
            end else if (fwd_hit) begin
                out_valid  = 1'b1;
                out_result = cpl_result;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking is kept to
    // function locals and always_comb.
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            pend     <= '0;
            mem_wr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            pend     <= '0;
            mem_wr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
            // a coincident response belongs to one of the requests being written off
            drop_cnt <= drop_cnt + pend_cnt
                      - CNT_W'(dcache_data_ok && ((drop_cnt != '0) || (pend_cnt != '0)));
        end else begin
            if (enq)     tail   <= tail + 1'b1;
            if (enq_mem) mem_wr <= mem_wr + 1'b1;
            if (deq)     head   <= head + 1'b1;
            if (cpl)     pend   <= pend + 1'b1;
            if (drop)    drop_cnt <= drop_cnt - 1'b1;
            count    <= count + CNT_W'(enq) - CNT_W'(deq);
            pend_cnt <= pend_cnt + CNT_W'(enq_mem) - CNT_W'(cpl);
        end
    end

    // NOTE: entry storage is not reset; count and pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            e_done[tail]    <= !in_is_mem;
            e_is_load[tail] <= in_is_load;
            e_ld_type[tail] <= in_ld_type;
            e_off[tail]     <= in_offset;
            e_rt[tail]      <= in_rt_value;
            e_result[tail]  <= in_result;
            e_payload[tail] <= in_payload;
        end
        if (enq_mem) mem_idx[mem_wr] <= tail;
        if (cpl) begin
            e_done[cpl_slot]   <= 1'b1;
            e_result[cpl_slot] <= cpl_result;
        end
    end

endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed self-checking bench for mem_resp_queue (DEPTH=4); follows MEM_RESP_FWD_EN
// for the response-to-out_valid latency.
module tb_mem_resp_queue;

    localparam logic [6:0] LB  = 7'b1000000;
    localparam logic [6:0] LBU = 7'b0100000;
    localparam logic [6:0] LH  = 7'b0010000;
    localparam logic [6:0] LHU = 7'b0001000;
    localparam logic [6:0] LW  = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010;
    localparam logic [6:0] LWR = 7'b0000001;

`ifdef MEM_RESP_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_is_mem, in_is_load;
    logic [6:0]  in_ld_type;
    logic [1:0]  in_offset;
    logic [31:0] in_rt_value, in_result;
    logic [63:0] in_payload;
    logic        dcache_data_ok;
    logic [31:0] dcache_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [63:0] out_payload;
    logic        flush;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    mem_resp_queue #(.DEPTH(4), .PAYLOAD_W(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem),
        .in_is_load(in_is_load), .in_ld_type(in_ld_type), .in_offset(in_offset),
        .in_rt_value(in_rt_value), .in_result(in_result), .in_payload(in_payload),
        .dcache_data_ok(dcache_data_ok), .dcache_rdata(dcache_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_payload(out_payload), .flush(flush), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 0; in_is_mem = 0; in_is_load = 0; in_ld_type = '0; in_offset = '0;
        in_rt_value = '0; in_result = '0; in_payload = '0;
        dcache_data_ok = 0; dcache_rdata = '0; out_ready = 0; flush = 0;
    endtask

    task automatic enq_lw(input logic [63:0] pl);
        in_valid = 1; in_is_mem = 1; in_is_load = 1; in_ld_type = LW; in_offset = 0;
        in_payload = pl;
        tick;
        in_valid = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        idle;
        repeat (2) tick;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
        reset = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
        tick;
    endtask

    task automatic test_non_mem;
        out_ready = 1; in_valid = 1; in_is_mem = 0; in_result = 32'h1234; in_payload = 64'h11;
        tick;
        in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h1234) begin
            errors++; $display("FAIL non_mem_result got v=%0b %h want v=1 00001234", out_valid, out_result); end
        checks++; if (out_payload !== 64'h11) begin errors++; $display("FAIL non_mem_payload got %h want 11", out_payload); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL non_mem_outstanding got %0d want 0", outstanding); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL non_mem_retired got %0b want 0", out_valid); end
        idle;
    endtask

    task automatic run_load(input string name, input logic is_load, input logic [6:0] t,
                            input logic [1:0] off, input logic [31:0] rt, input logic [31:0] res,
                            input logic [31:0] rdata, input logic [31:0] exp);
        out_ready = 0; in_valid = 1; in_is_mem = 1; in_is_load = is_load; in_ld_type = t;
        in_offset = off; in_rt_value = rt; in_result = res; in_payload = 64'hCAFE;
        tick;
        in_valid = 0; dcache_data_ok = 1; dcache_rdata = rdata;
        #1;
        checks++; if (out_valid !== FWD) begin errors++; $display("FAIL %s_resp_cycle_valid got %0b want %0b", name, out_valid, FWD); end
        tick;
        dcache_data_ok = 0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_result !== exp) begin
            errors++; $display("FAIL %s got v=%0b %h want v=1 %h", name, out_valid, out_result, exp); end
        out_ready = 1;
        tick;
        out_ready = 0;
        idle;
    endtask

    task automatic test_load_align;
        run_load("lbu_o1", 1, LBU, 2'd1, 32'h0, 32'h0, 32'h1234_80FF, 32'h0000_0080);
        run_load("lb_o2",  1, LB,  2'd2, 32'h0, 32'h0, 32'h00F0_0000, 32'hFFFF_FFF0);
        run_load("lb_o3",  1, LB,  2'd3, 32'h0, 32'h0, 32'h7F00_0000, 32'h0000_007F);
        run_load("lh_o2",  1, LH,  2'd2, 32'h0, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001);
        run_load("lh_o1",  1, LH,  2'd1, 32'h0, 32'h0, 32'h8001_7FFF, 32'h0000_7FFF);
        run_load("lhu_o0", 1, LHU, 2'd0, 32'h0, 32'h0, 32'h8001_F00F, 32'h0000_F00F);
        run_load("lw",     1, LW,  2'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_load("lwl_o0", 1, LWL, 2'd0, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'h44BB_CCDD);
        run_load("lwl_o1", 1, LWL, 2'd1, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'h3344_CCDD);
        run_load("lwl_o3", 1, LWL, 2'd3, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'h1122_3344);
        run_load("lwr_o0", 1, LWR, 2'd0, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'h1122_3344);
        run_load("lwr_o1", 1, LWR, 2'd1, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'hAA11_2233);
        run_load("lwr_o3", 1, LWR, 2'd3, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 32'hAABB_CC11);
        run_load("store",  0, 7'h0, 2'd0, 32'h0, 32'h0000_5555, 32'hFFFF_FFFF, 32'h0000_5555);
    endtask

    task automatic test_fwd_latency;
        out_ready = 1; in_valid = 1; in_is_mem = 1; in_is_load = 1; in_ld_type = LB; in_offset = 2;
        tick;
        in_valid = 0; dcache_data_ok = 1; dcache_rdata = 32'h00F0_0000;
        #1;
        checks++; if (out_valid !== FWD || (FWD && out_result !== 32'hFFFF_FFF0)) begin
            errors++; $display("FAIL lat_same_cycle got v=%0b %h want v=%0b", out_valid, out_result, FWD); end
        tick;
        dcache_data_ok = 0;
        #1;
        checks++; if (out_valid !== !FWD || (!FWD && out_result !== 32'hFFFF_FFF0)) begin
            errors++; $display("FAIL lat_next_cycle got v=%0b %h want v=%0b", out_valid, out_result, !FWD); end
        tick;
        checks++; if (out_valid !== 1'b0 || outstanding !== 3'd0) begin
            errors++; $display("FAIL lat_drained got v=%0b out=%0d want v=0 out=0", out_valid, outstanding); end
        idle;
    endtask

    task automatic test_fill_wrap;
        int n_ret;
        for (int i = 0; i < 4; i++) enq_lw(64'(i));
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding got %0d want 4", outstanding); end
        n_ret = 0;
        out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            dcache_data_ok = (c < 4);
            dcache_rdata = 32'h100 + 32'(c);
            #1;
            if (out_valid) begin
                checks++; if (out_result !== 32'h100 + 32'(n_ret) || out_payload !== 64'(n_ret)) begin
                    errors++; $display("FAIL fill_order[%0d] got %h/%h want %h/%h", n_ret, out_result,
                                       out_payload, 32'h100 + 32'(n_ret), 64'(n_ret)); end
                n_ret++;
            end
            tick;
        end
        dcache_data_ok = 0;
        #1;
        checks++; if (n_ret !== 4) begin errors++; $display("FAIL fill_retired got %0d want 4", n_ret); end
        checks++; if (in_ready !== 1'b1 || outstanding !== 3'd0) begin
            errors++; $display("FAIL fill_drained got rdy=%0b out=%0d want rdy=1 out=0", in_ready, outstanding); end
        tick;
        idle;
    endtask

    task automatic test_flush_drop;
        in_valid = 1; in_is_mem = 0; in_result = 32'h99;
        tick;
        for (int i = 0; i < 3; i++) enq_lw(64'h50 + 64'(i));
        #1;
        checks++; if (out_valid !== 1'b1 || outstanding !== 3'd3) begin
            errors++; $display("FAIL pre_flush got v=%0b out=%0d want v=1 out=3", out_valid, outstanding); end
        flush = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_cycle got v=%0b rdy=%0b want 0 0", out_valid, in_ready); end
        tick;
        flush = 0;
        #1;
        checks++; if (outstanding !== 3'd3 || out_valid !== 1'b0) begin
            errors++; $display("FAIL post_flush got out=%0d v=%0b want 3 0", outstanding, out_valid); end
        enq_lw(64'h77);
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL flush_new_outstanding got %0d want 4", outstanding); end
        for (int i = 0; i < 3; i++) begin
            dcache_data_ok = 1; dcache_rdata = 32'hBAD0 + 32'(i);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dropped_resp[%0d] got v=%0b want 0", i, out_valid); end
            tick;
        end
        dcache_data_ok = 0;
        #1;
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL drops_done got %0d want 1", outstanding); end
        dcache_data_ok = 1; dcache_rdata = 32'h600D;
        tick;
        dcache_data_ok = 0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h600D || out_payload !== 64'h77) begin
            errors++; $display("FAIL post_flush_load got v=%0b %h/%h want v=1 0000600d/77", out_valid, out_result, out_payload); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL post_flush_outstanding got %0d want 0", outstanding); end
        out_ready = 1;
        tick;
        idle;
    endtask

    task automatic test_flush_coincident;
        enq_lw(64'h1);
        enq_lw(64'h2);
        flush = 1; dcache_data_ok = 1; dcache_rdata = 32'hBAD;
        tick;
        flush = 0; dcache_data_ok = 0;
        #1;
        checks++; if (outstanding !== 3'd1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL coinc_flush got out=%0d v=%0b want 1 0", outstanding, out_valid); end
        dcache_data_ok = 1;
        tick;
        #1;
        checks++; if (outstanding !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL coinc_drop got out=%0d v=%0b want 0 0", outstanding, out_valid); end
        tick;
        dcache_data_ok = 0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL spurious_resp got %0d want 0", outstanding); end
        enq_lw(64'h3);
        dcache_data_ok = 1; dcache_rdata = 32'hABCD;
        tick;
        dcache_data_ok = 0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hABCD) begin
            errors++; $display("FAIL after_spurious got v=%0b %h want v=1 0000abcd", out_valid, out_result); end
        out_ready = 1;
        tick;
        idle;
    endtask

    task automatic test_back_to_back;
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_is_mem = 0; in_result = 32'h500 + 32'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, in_ready); end
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_result !== 32'h500 + 32'(i - 1)) begin
                    errors++; $display("FAIL b2b_out[%0d] got v=%0b %h want v=1 %h", i, out_valid, out_result,
                                       32'h500 + 32'(i - 1)); end
            end
            tick;
        end
        in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h505) begin
            errors++; $display("FAIL b2b_last got v=%0b %h want v=1 00000505", out_valid, out_result); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", out_valid); end
        idle;
    endtask

    initial begin
        test_reset;
        test_non_mem;
        test_load_align;
        test_fwd_latency;
        test_fill_wrap;
        test_flush_drop;
        test_flush_coincident;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
